// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3/APB4 initiator: valid/ready request in, one SETUP/ACCESS transfer out, valid/ready response back.
// Optional ACCESS watchdog is built only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_write,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [2:0]          req_prot,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Elaboration stops on an unknown module name if the configuration is illegal.
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    data_w_must_be_a_multiple_of_8 u_bad_data_w ();
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    timeout_cycles_must_be_positive u_bad_timeout ();
  end

  logic [1:0] state;

  // Accept only from IDLE; deliberately no path from req_valid.
  assign req_ready = (state == S_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;

  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: all state lives in one clocked block and uses non-blocking assignments,
  // so every register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_paddr   <= '0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
      out_pprot   <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            out_paddr   <= req_addr;
            out_pwrite  <= req_write;
            out_pprot   <= req_prot;
            out_pwdata  <= req_write ? req_wdata : '0;
            out_pstrb   <= req_write ? req_wstrb : '0;
            out_psel    <= 1'b1;
            out_penable <= 1'b0;
            state       <= S_SETUP;
          end
        end

        S_SETUP: begin
          out_penable <= 1'b1;
          state       <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end

        S_ACCESS: begin
          if (out_pready) begin
            resp_rdata  <= out_pwrite ? '0 : out_prdata;
            resp_err    <= out_pslverr;
            resp_valid  <= 1'b1;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            state       <= S_RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (timed_out) begin
            resp_rdata  <= '0;
            resp_err    <= 1'b1;
            resp_valid  <= 1'b1;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            state       <= S_RESP;
          end else begin
            wait_cnt    <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: a per-transaction timeline model predicts every output each cycle.
// Build with APB_MASTER_TIMEOUT_EN defined to exercise the ACCESS watchdog instead of the hang case.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic [2:0]    req_prot;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          out_psel;
  logic          out_penable;
  logic [2:0]    out_pprot;
  logic [AW-1:0] out_paddr;
  logic          out_pwrite;
  logic [DW-1:0] out_pwdata;
  logic [SW-1:0] out_pstrb;
  logic          out_pready;
  logic [DW-1:0] out_prdata;
  logic          out_pslverr;

  apb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_prot(req_prot),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_paddr(out_paddr), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model of the transfer in flight: k = cycles since the acceptance edge.
  // k=0 SETUP, k=1..1+nw ACCESS, k=2+nw..2+nw+nd response shown, later idle.
  bit          chk_en = 1'b0;
  bit          act    = 1'b0;
  int          t_acc, nw, nd;
  bit          m_write, m_err, m_hang;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;

  int k_c;
  bit e_psel, e_pen, e_rv, e_idle;

  always @(negedge clk) begin
    if (chk_en) begin
      k_c    = cyc - t_acc;
      e_psel = act && (m_hang || k_c <= 1 + nw);
      e_pen  = e_psel && k_c >= 1;
      e_rv   = act && !m_hang && k_c >= 2 + nw && k_c <= 2 + nw + nd;
      e_idle = !act || (!m_hang && k_c > 2 + nw + nd);
      check("psel", out_psel, e_psel);
      check("penable", out_penable, e_pen);
      check("resp_valid", resp_valid, e_rv);
      check("req_ready", req_ready, e_idle);
      if (e_psel) begin
        check("paddr", out_paddr, m_addr);
        check("pwrite", out_pwrite, m_write);
        check("pwdata", out_pwdata, m_write ? m_wdata : 32'h0);
        check("pstrb", out_pstrb, m_write ? m_strb : 4'h0);
        check("pprot", out_pprot, m_prot);
      end
      if (e_rv) begin
        check("resp_rdata", resp_rdata, m_write ? 32'h0 : m_rdata);
        check("resp_err", resp_err, m_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_req();
    req_valid = 1'($urandom);
    req_addr  = $urandom;
    req_write = 1'($urandom);
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    req_prot  = 3'($urandom);
  endtask

  // One request through the bridge. to: expect watchdog; hang: never answer;
  // abort_at >= 0: assert reset during that ACCESS cycle. pin selects literal spot-checks.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input int dly, input logic [31:0] rdata, input bit err, input bit to,
                        input bit hang, input int abort_at, input int pin);
    int  k;
    bit  done;
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wdata;
    req_wstrb   = strb;
    req_prot    = prot;
    resp_ready  = 1'($urandom);
    out_pready  = 1'($urandom);
    out_prdata  = $urandom;
    out_pslverr = 1'($urandom);
    step();
    t_acc   = cyc;
    m_write = wr;
    m_addr  = addr;
    m_wdata = wdata;
    m_strb  = strb;
    m_prot  = prot;
    nw      = waits;
    nd      = dly;
    m_err   = to ? 1'b1 : err;
    m_rdata = to ? 32'h0 : rdata;
    m_hang  = hang;
    act     = 1'b1;
    done    = 1'b0;
    while (!done) begin
      k = cyc - t_acc;
      if (pin == 1 && k == 0) begin
        check("pin_wr_setup_psel", out_psel, 1'b1);
        check("pin_wr_setup_penable", out_penable, 1'b0);
      end
      if (pin == 1 && k == 1) begin
        check("pin_wr_access_penable", out_penable, 1'b1);
        check("pin_wr_access_pstrb", out_pstrb, 4'h1);
        check("pin_wr_access_pwdata", out_pwdata, 32'h0000_0041);
      end
      if (pin == 1 && k == 2) begin
        check("pin_wr_resp_valid", resp_valid, 1'b1);
        check("pin_wr_resp_rdata", resp_rdata, 32'h0);
        check("pin_wr_resp_err", resp_err, 1'b0);
      end
      if (pin == 2 && k >= 1 && k <= 4) begin
        check("pin_rd_access_penable", out_penable, 1'b1);
        check("pin_rd_access_paddr", out_paddr, 32'h2000_0010);
        check("pin_rd_access_pstrb", out_pstrb, 4'h0);
      end
      if (pin == 2 && k == 5) begin
        check("pin_rd_resp_valid", resp_valid, 1'b1);
        check("pin_rd_resp_rdata", resp_rdata, 32'h5A5A_5A5A);
      end
      if (pin == 3 && k == TO + 1) begin
        check("pin_to_resp_valid", resp_valid, 1'b1);
        check("pin_to_resp_err", resp_err, 1'b1);
        check("pin_to_resp_rdata", resp_rdata, 32'h0);
      end
      if (pin == 4 && k == 300) begin
        check("pin_hang_psel", out_psel, 1'b1);
        check("pin_hang_penable", out_penable, 1'b1);
        check("pin_hang_resp_valid", resp_valid, 1'b0);
      end
      if (!hang && k == 3 + waits + dly) begin
        done = 1'b1;
      end else begin
        scramble_req();
        out_prdata  = $urandom;
        out_pslverr = 1'($urandom);
        if (k >= 1 && (hang || k <= 1 + waits)) begin
          out_pready = (k == 1 + waits) && !to && !hang;
          if (out_pready) begin
            out_prdata  = rdata;
            out_pslverr = err;
          end
        end else begin
          out_pready = 1'($urandom);
        end
        if (k == 2 + waits + dly)  resp_ready = 1'b1;
        else if (k < 2 + waits)    resp_ready = 1'($urandom);
        else                       resp_ready = 1'b0;
        reset = (abort_at >= 0 && k == abort_at);
        step();
        if (reset) begin
          reset = 1'b0;
          act   = 1'b0;
          check("abort_psel", out_psel, 1'b0);
          check("abort_penable", out_penable, 1'b0);
          check("abort_resp_valid", resp_valid, 1'b0);
          check("abort_req_ready", req_ready, 1'b1);
          done  = 1'b1;
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid   = 1'b0;
      resp_ready  = 1'($urandom);
      out_pready  = 1'($urandom);
      out_prdata  = $urandom;
      out_pslverr = 1'($urandom);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_write   = 1'b0;
    req_wdata   = '0;
    req_wstrb   = '0;
    req_prot    = '0;
    resp_ready  = 1'b0;
    out_pready  = 1'b0;
    out_prdata  = '0;
    out_pslverr = 1'b0;
    repeat (3) step();
    check("rst_psel", out_psel, 1'b0);
    check("rst_penable", out_penable, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_paddr", out_paddr, 32'h0);
    check("rst_pwdata", out_pwdata, 32'h0);
    check("rst_pstrb", out_pstrb, 4'h0);
    check("rst_pprot", out_pprot, 3'h0);
    check("rst_pwrite", out_pwrite, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    chk_en = 1'b1;
    idle_cycles(2);

    // Zero-wait write.
    do_txn(1'b1, 32'h1000_0000, 32'h0000_0041, 4'h1, 3'b000, 0, 0, $urandom, 1'b0, 1'b0, 1'b0, -1, 1);
    // Read with three wait states, issued back-to-back.
    do_txn(1'b0, 32'h2000_0010, $urandom, 4'hF, 3'b010, 3, 0, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0, -1, 2);
    // Slave error, then a clean follow-up.
    do_txn(1'b0, 32'h3000_0004, $urandom, 4'h3, 3'b001, 1, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, -1, 0);
    do_txn(1'b0, 32'h3000_0008, $urandom, 4'h3, 3'b001, 0, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, -1, 0);
    // Response backpressure for five cycles.
    do_txn(1'b0, 32'h4000_0000, $urandom, 4'h0, 3'b111, 2, 5, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, -1, 0);
    idle_cycles(1);
    // Reset during a wait state; nothing may come back afterwards.
    do_txn(1'b1, 32'h5000_0000, 32'hAAAA_5555, 4'hF, 3'b100, 4, 0, $urandom, 1'b0, 1'b0, 1'b0, 2, 0);
    idle_cycles(4);

`ifdef APB_MASTER_TIMEOUT_EN
    do_txn(1'b0, 32'h6000_0000, $urandom, 4'h0, 3'b000, TO - 1, 2, $urandom, 1'b0, 1'b1, 1'b0, -1, 3);
`else
    do_txn(1'b0, 32'h6000_0000, $urandom, 4'h0, 3'b000, 0, 0, $urandom, 1'b0, 1'b0, 1'b1, 300, 4);
`endif
    idle_cycles(2);

    for (int i = 0; i < 60; i++) begin
      int w;
      int ab;
      w  = int'($urandom_range(0, 4));
      ab = (w > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, w)) : -1;
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom), w,
             int'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'b0, 1'b0, ab, 0);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(2);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
